// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage data memory with sized loads/stores, configurable read latency and error reporting
module data_mem_unit #(
  parameter int DEPTH_WORDS = 512,
  parameter int RD_LATENCY  = 1
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RD_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, err, wr_en, last, err_q;
  logic [1:0] lane;
  logic [AW-1:0] idx;
  logic [15:0] sh;
  logic [31:0] word, ld, wd, mask, data_q;
  logic [3:0] be;
  assign lane   = req_addr[1:0];
  assign idx    = req_addr[AW+1:2];
  assign accept = req_valid & req_ready;
  assign err    = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                  (req_size == 2'b10 & |lane) | (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign word   = mem[idx];
  assign sh     = 16'(word >> {lane, 3'b000});
  assign ld     = req_size == 2'b00 ? {{24{~req_unsigned & sh[7]}}, sh[7:0]} :
                  req_size == 2'b01 ? {{16{~req_unsigned & sh[15]}}, sh[15:0]} : word;
  assign wd     = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                  req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign be     = req_size == 2'b00 ? 4'b0001 << lane :
                  req_size == 2'b01 ? 4'b0011 << lane : 4'b1111;
  assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_en  = accept & req_we & ~err;
  assign req_ready = state != WAIT;
  assign stall     = req_valid & ~req_ready;
  assign rsp_valid = state == RESP;
  assign rsp_rdata = rsp_valid ? data_q : '0;
  assign rsp_err   = rsp_valid & err_q;
  always_comb begin
    last    = cnt == CW'(RD_LATENCY - 1);
    state_d = state == WAIT ? (last ? RESP : WAIT) :
              accept ? (RD_LATENCY > 1 ? WAIT : RESP) : IDLE;
    cnt_d   = (state == WAIT & ~last) ? cnt + 1'b1 :
              (state != WAIT & accept & RD_LATENCY > 1) ? CW'(1) : '0;
  end
  // Array has no reset; reset only blocks a store sampled on the same edge
  always_ff @(posedge CLK)
    if (reset_n && wr_en) mem[idx] <= (word & ~mask) | (wd & mask);
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        data_q <= (req_we | err) ? '0 : ld;
        err_q  <= err;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: scoreboard bench for data_mem_unit at read latencies 1 and 3
module tb_data_mem_unit;
  logic CLK = 0, reset_n = 0, v1 = 0, v3 = 0, we = 0, uns = 0;
  logic [1:0] size = 2'b10;
  logic [31:0] addr = 0, wdata = 0;
  logic rdy1, rv1, err1, stall1, rdy3, rv3, err3, stall3;
  logic [31:0] rd1, rd3;
  logic [32:0] q1[$], q3[$];
  logic [32:0] e1, e3;
  int vectors = 0, miscompares = 0;

  data_mem_unit #(.DEPTH_WORDS(512), .RD_LATENCY(1)) d1 (
    .CLK(CLK), .reset_n(reset_n), .req_valid(v1), .req_ready(rdy1), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1), .stall(stall1));
  data_mem_unit #(.DEPTH_WORDS(512), .RD_LATENCY(3)) d3 (
    .CLK(CLK), .reset_n(reset_n), .req_valid(v3), .req_ready(rdy3), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3), .stall(stall3));

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge CLK) begin
    vectors++;
    if (rv1) begin
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL rsp1_unexpected: got err=%0b data=%h, required no response", err1, rd1);
      end else begin
        e1 = q1.pop_front();
        if ({err1, rd1} !== e1) begin
          miscompares++;
          $display("FAIL rsp1: got err=%0b data=%h, required err=%0b data=%h", err1, rd1, e1[32], e1[31:0]);
        end
      end
    end else if ({err1, rd1} !== 33'd0) begin
      miscompares++;
      $display("FAIL rsp1_idle: got err=%0b data=%h, required 0", err1, rd1);
    end
  end

  always @(negedge CLK) begin
    vectors++;
    if (rv3) begin
      if (q3.size() == 0) begin
        miscompares++;
        $display("FAIL rsp3_unexpected: got err=%0b data=%h, required no response", err3, rd3);
      end else begin
        e3 = q3.pop_front();
        if ({err3, rd3} !== e3) begin
          miscompares++;
          $display("FAIL rsp3: got err=%0b data=%h, required err=%0b data=%h", err3, rd3, e3[32], e3[31:0]);
        end
      end
    end else if ({err3, rd3} !== 33'd0) begin
      miscompares++;
      $display("FAIL rsp3_idle: got err=%0b data=%h, required 0", err3, rd3);
    end
  end

  task automatic drive(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
    we = w; size = s; uns = u; addr = a; wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic issue1(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] d, input logic ee, input logic [31:0] ed);
    drive(w, s, u, a, d);
    v1 = 1;
    q1.push_back({ee, ed});
    @(posedge CLK) #1;
    v1 = 0;
  endtask

  task automatic issue3(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] d, input logic ee, input logic [31:0] ed);
    logic acc;
    int n;
    drive(w, s, u, a, d);
    v3 = 1;
    n = 0;
    do begin
      @(negedge CLK);
      acc = rdy3;
      @(posedge CLK) #1;
      n++;
    end while (!acc && n < 20);
    v3 = 0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL issue3_timeout: got ready=0 for %0d cycles, required accept", n);
    end else q3.push_back({ee, ed});
  endtask

  task automatic test_reset;
    issue1(1, 2'b10, 0, 32'h0, 32'h11223344, 0, 0);
    idle(3);
    drive(1, 2'b10, 0, 32'h0, 32'hFFFFFFFF);
    v1 = 1;
    reset_n = 0;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      vectors++;
      if (rv1 !== 1'b0 || rd1 !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_out: got valid=%0b data=%h, required 0/0", rv1, rd1);
      end
    end
    reset_n = 1;
    v1 = 0;
    @(posedge CLK) #1;
    vectors++;
    if (rdy1 !== 1'b1 || rdy3 !== 1'b1 || rv1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready1=%0b ready3=%0b valid=%0b, required 1/1/0", rdy1, rdy3, rv1);
    end
    issue1(0, 2'b10, 0, 32'h0, 0, 0, 32'h11223344);
    idle(2);
  endtask

  task automatic test_extend;
    issue1(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    issue1(0, 2'b00, 0, 32'h11, 0, 0, 32'hFFFFFFBE);
    issue1(0, 2'b00, 1, 32'h13, 0, 0, 32'h000000DE);
    issue1(0, 2'b01, 0, 32'h12, 0, 0, 32'hFFFFDEAD);
    issue1(0, 2'b01, 1, 32'h10, 0, 0, 32'h0000BEEF);
    issue1(0, 2'b00, 0, 32'h10, 0, 0, 32'hFFFFFFEF);
    idle(2);
  endtask

  task automatic test_store_forward;
    issue1(1, 2'b00, 0, 32'h12, 32'hFFFFFF5A, 0, 0);
    issue1(0, 2'b10, 0, 32'h10, 0, 0, 32'hDE5ABEEF);
    issue1(1, 2'b01, 0, 32'h10, 32'hAAAA1234, 0, 0);
    issue1(0, 2'b10, 0, 32'h10, 0, 0, 32'hDE5A1234);
    idle(2);
  endtask

  task automatic test_errors;
    issue1(0, 2'b10, 0, 32'h06, 0, 1, 0);
    issue1(1, 2'b10, 0, 32'h800, 32'hFFFFFFFF, 1, 0);
    issue1(0, 2'b10, 0, 32'h0, 0, 0, 32'h11223344);
    issue1(0, 2'b11, 0, 32'h0, 0, 1, 0);
    issue1(0, 2'b01, 0, 32'h11, 0, 1, 0);
    issue1(1, 2'b10, 0, 32'h7FC, 32'h0BADCAFE, 0, 0);
    issue1(0, 2'b10, 0, 32'h7FC, 0, 0, 32'h0BADCAFE);
    idle(2);
  endtask

  task automatic test_back_to_back;
    issue1(1, 2'b10, 0, 32'h4, 32'h55667788, 0, 0);
    issue1(1, 2'b10, 0, 32'h8, 32'h99AABBCC, 0, 0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        drive(0, 2'b10, 0, 32'(4 * i), 0);
        v1 = 1;
        q1.push_back({1'b0, i == 0 ? 32'h11223344 : i == 1 ? 32'h55667788 : 32'h99AABBCC});
      end else v1 = 0;
      @(negedge CLK);
      vectors++;
      if (stall1 !== 1'b0 || rv1 !== (i > 0)) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got stall=%0b valid=%0b, required 0/%0b", i, stall1, rv1, i > 0);
      end
      @(posedge CLK) #1;
    end
    idle(2);
  endtask

  task automatic test_latency;
    issue3(1, 2'b10, 0, 32'h10, 32'hA5A5A5A5, 0, 0);
    idle(4);
    drive(0, 2'b10, 0, 32'h10, 0);
    v3 = 1;
    q3.push_back({1'b0, 32'hA5A5A5A5});
    @(posedge CLK) #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      vectors++;
      if (rdy3 !== 1'b0 || stall3 !== 1'b1 || rv3 !== 1'b0) begin
        miscompares++;
        $display("FAIL wait[%0d]: got ready=%0b stall=%0b valid=%0b, required 0/1/0", k, rdy3, stall3, rv3);
      end
      @(posedge CLK) #1;
    end
    @(negedge CLK);
    vectors++;
    if (rv3 !== 1'b1 || rdy3 !== 1'b1 || stall3 !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_edge: got valid=%0b ready=%0b stall=%0b, required 1/1/0", rv3, rdy3, stall3);
    end
    v3 = 0;
    @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (rv3 !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_single: got valid=%0b, required 0", rv3);
    end
    @(posedge CLK) #1;
    issue3(0, 2'b10, 0, 32'h06, 0, 1, 0);
    idle(4);
  endtask

  task automatic test_reset_in_wait;
    int seen;
    drive(0, 2'b10, 0, 32'h10, 0);
    v3 = 1;
    @(posedge CLK) #1;
    v3 = 0;
    reset_n = 0;
    @(posedge CLK) #1;
    reset_n = 1;
    seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (rv3) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_in_wait: got %0d responses, required 0", seen);
    end
    @(posedge CLK) #1;
    issue3(0, 2'b10, 0, 32'h10, 0, 0, 32'hA5A5A5A5);
    idle(5);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    reset_n = 1;
    test_reset;
    test_extend;
    test_store_forward;
    test_errors;
    test_back_to_back;
    test_latency;
    test_reset_in_wait;
    idle(6);
    vectors++;
    if (q1.size() != 0 || q3.size() != 0) begin
      miscompares++;
      $display("FAIL pending: got %0d/%0d outstanding responses, required 0/0", q1.size(), q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
